// File: rtl/timer_scheduler.sv
// Round-robin arbiter in front of one shared delay counter: the granted requester's
// delay is latched, counted 0..D, and answered with a one-cycle done pulse.
module timer_scheduler #(
   parameter int N_REQ = 4,
   parameter int W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ*W-1:0] delay,
   output logic [N_REQ-1:0]   gnt,
   output logic [N_REQ-1:0]   done,
   output logic               busy,
   output logic [W-1:0]       count
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   logic [1:0]       r_state;
   logic [PW-1:0]    r_ptr;
   logic [PW-1:0]    r_idx;
   logic [W-1:0]     r_final;
   logic [W-1:0]     r_count;

   logic             w_found;
   logic [PW-1:0]    w_sel;
   logic [PW-1:0]    w_scan;
   int               w_j;
   logic [PW-1:0]    w_idx_next;
   logic [N_REQ-1:0] w_idx_onehot;

   function automatic logic [PW-1:0] f_wrap_inc(input logic [PW-1:0] i);
      if (int'(i) == N_REQ - 1) begin
         return {PW{1'b0}};
      end else begin
         return i + 1'b1;
      end
   endfunction

   // First set request scanning upward from the priority pointer, wrapping at N_REQ-1.
   always_comb begin
      w_found = 1'b0;
      w_sel   = r_ptr;
      w_scan  = r_ptr;
      w_j     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         w_j = int'(r_ptr) + k;
         if (w_j >= N_REQ) begin
            w_j = w_j - N_REQ;
         end else begin
            w_j = w_j;
         end
         w_scan = PW'(w_j);
         if (!w_found && req[w_scan]) begin
            w_found = 1'b1;
            w_sel   = w_scan;
         end else begin
            w_found = w_found;
         end
      end
   end

   assign w_idx_next   = f_wrap_inc(r_idx);
   assign w_idx_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_idx;

   // Abort beats completion; the finished or aborted requester drops to lowest priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_ptr   <= {PW{1'b0}};
         r_idx   <= {PW{1'b0}};
         r_final <= {W{1'b0}};
         r_count <= {W{1'b0}};
      end else begin
         case (r_state)
            S_IDLE: begin
               r_count <= {W{1'b0}};
               if (w_found) begin
                  r_idx   <= w_sel;
                  r_final <= delay[int'(w_sel)*W +: W];
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (!req[r_idx]) begin
                  r_state <= S_IDLE;
                  r_ptr   <= w_idx_next;
                  r_count <= {W{1'b0}};
               end else if (r_count == r_final) begin
                  r_state <= S_ACK;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            S_ACK: begin
               r_state <= S_IDLE;
               r_ptr   <= w_idx_next;
               r_count <= {W{1'b0}};
            end
            default: begin
               r_state <= S_IDLE;
               r_count <= {W{1'b0}};
            end
         endcase
      end
   end

   assign busy  = (r_state != S_IDLE);
   assign gnt   = busy ? w_idx_onehot : {N_REQ{1'b0}};
   assign done  = (r_state == S_ACK) ? w_idx_onehot : {N_REQ{1'b0}};
   assign count = r_count;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: a vector table of complete runs followed by
// hand-written abort, mid-run delay change and mid-run reset sequences.
module tb_timer_scheduler;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] req;
   logic [N*W-1:0] delay;
   logic [N-1:0] gnt;
   logic [N-1:0] done;
   logic         busy;
   logic [W-1:0] count;

   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0]  r;
      logic [31:0] d;
      logic [3:0]  eg;
      int          dl;
   } vec_t;

   vec_t tbl[12];

   timer_scheduler #(.N_REQ(N), .W(W)) dut (
      .clk(clk), .reset(reset), .req(req), .delay(delay),
      .gnt(gnt), .done(done), .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full run from IDLE: grant, count 0..dl, done, then one idle cycle.
   task automatic run_one(input string tag, input logic [3:0] r, input logic [31:0] d,
                          input logic [3:0] eg, input int dl);
      req   = r;
      delay = d;
      tick();
      chk({tag, " gnt"}, 32'(gnt), 32'(eg));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " count0"}, 32'(count), 32'd0);
      chk({tag, " done0"}, 32'(done), 32'd0);
      for (int k = 1; k <= dl; k++) begin
         tick();
         chk($sformatf("%s count%0d", tag, k), 32'(count), 32'(k));
         chk($sformatf("%s nodone%0d", tag, k), 32'(done), 32'd0);
      end
      tick();
      chk({tag, " done"}, 32'(done), 32'(eg));
      chk({tag, " ackgnt"}, 32'(gnt), 32'(eg));
      chk({tag, " ackcount"}, 32'(count), 32'(dl));
      req = req & ~eg;
      tick();
      chk({tag, " idlebusy"}, 32'(busy), 32'd0);
      chk({tag, " idlegnt"}, 32'(gnt), 32'd0);
      chk({tag, " idledone"}, 32'(done), 32'd0);
      chk({tag, " idlecount"}, 32'(count), 32'd0);
   endtask

   initial begin
      tbl[0]  = '{4'b1111, 32'h02020202, 4'b0001, 2};
      tbl[1]  = '{4'b1110, 32'h02020202, 4'b0010, 2};
      tbl[2]  = '{4'b1100, 32'h02020202, 4'b0100, 2};
      tbl[3]  = '{4'b1000, 32'h02020202, 4'b1000, 2};
      tbl[4]  = '{4'b1001, 32'h02020202, 4'b0001, 2};
      tbl[5]  = '{4'b1000, 32'h02020202, 4'b1000, 2};
      tbl[6]  = '{4'b0100, 32'h00050000, 4'b0100, 5};
      tbl[7]  = '{4'b0010, 32'h00000000, 4'b0010, 0};
      tbl[8]  = '{4'b1000, 32'hFF000000, 4'b1000, 255};
      tbl[9]  = '{4'b0110, 32'h00000700, 4'b0010, 7};
      tbl[10] = '{4'b0101, 32'h00030000, 4'b0100, 3};
      tbl[11] = '{4'b0001, 32'h00000001, 4'b0001, 1};

      reset = 1'b1;
      req   = 4'b1111;
      delay = 32'h02020202;
      repeat (3) tick();
      chk("rst gnt", 32'(gnt), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst count", 32'(count), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_one($sformatf("v%0d", i), tbl[i].r, tbl[i].d, tbl[i].eg, tbl[i].dl);
      end

      // Abort: requester 1 drops at count 4, pending requester 0 wins after wrap.
      req   = 4'b0011;
      delay = 32'h00000A01;
      tick();
      chk("abort gnt", 32'(gnt), 32'h2);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("abort count%0d", k), 32'(count), 32'(k));
      end
      req = 4'b0001;
      tick();
      chk("abort gntclr", 32'(gnt), 32'd0);
      chk("abort busyclr", 32'(busy), 32'd0);
      chk("abort nodone", 32'(done), 32'd0);
      chk("abort countclr", 32'(count), 32'd0);
      tick();
      chk("abort next gnt", 32'(gnt), 32'h1);
      tick();
      chk("abort next count1", 32'(count), 32'd1);
      tick();
      chk("abort next done", 32'(done), 32'h1);
      req = 4'b0000;
      tick();
      chk("abort next idle", 32'(busy), 32'd0);

      // Delay changed after the grant edge must be ignored.
      req   = 4'b0100;
      delay = 32'h00050000;
      tick();
      chk("latch gnt", 32'(gnt), 32'h4);
      delay = 32'h00010000;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk($sformatf("latch count%0d", k), 32'(count), 32'(k));
         chk($sformatf("latch nodone%0d", k), 32'(done), 32'd0);
      end
      tick();
      chk("latch done", 32'(done), 32'h4);
      req = 4'b0000;
      tick();
      chk("latch idle", 32'(busy), 32'd0);

      // Reset mid-run clears outputs at once and the pointer returns to 0.
      req   = 4'b0001;
      delay = 32'h00000007;
      tick();
      chk("rrun gnt", 32'(gnt), 32'h1);
      repeat (3) tick();
      chk("rrun count3", 32'(count), 32'd3);
      reset = 1'b1;
      #1;
      chk("rrun gntclr", 32'(gnt), 32'd0);
      chk("rrun busyclr", 32'(busy), 32'd0);
      chk("rrun doneclr", 32'(done), 32'd0);
      chk("rrun countclr", 32'(count), 32'd0);
      req = 4'b0000;
      tick();
      reset = 1'b0;
      repeat (2) tick();
      chk("rrun noresume", 32'(busy), 32'd0);
      req = 4'b1001;
      tick();
      chk("rrun ptr0 gnt", 32'(gnt), 32'h1);
      chk("rrun ptr0 count", 32'(count), 32'd0);
      req = 4'b0000;
      tick();
      chk("rrun final idle", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Shares a single delay counter between `N_REQ` requesters using round-robin arbitration. Each requester asks for a delay of `D` cycles. The block grants one requester at a time, latches its delay, counts from 0 to `D`, then returns a one-cycle done pulse to that requester. It sits between the sequential control blocks and the shared timer resource, so several controllers can use one counter without colliding.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥2.
- `W`, default 8: delay/counter width in bits.

- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `req` input, `N_REQ` bits: per-requester request level; held high until done or withdrawn.
- `delay` input, `N_REQ*W` bits: packed delays; requester `i` uses bits `[i*W +: W]`.
- `gnt` output, `N_REQ` bits: one-hot grant; all zero when idle.
- `done` output, `N_REQ` bits: one-hot, one-cycle completion pulse to the granted requester.
- `busy` output, 1 bit: high whenever the state is not `IDLE`.
- `count` output, `W` bits: current counter value.

## Operation
- There are three states: `IDLE`, `RUN` and `ACK`. Internal registers are `state`, `ptr` (priority pointer, `log2(N_REQ)` bits), `idx` (granted index), `final_reg` (`W` bits) and `count` (`W` bits).
- **IDLE**
  - If `req` is nonzero, select the first set bit scanning upward from `ptr`, wrapping from `N_REQ-1` to 0.
  - On that edge: `idx` ← selected index; `final_reg` ← `delay[idx]`; `count` ← 0; state ← `RUN`.
  - If `req` is zero, stay in `IDLE` with `count` = 0.
- **RUN**
  - `gnt[idx]` = 1.
  - If `req[idx]` = 0, abort. Next state is `IDLE`, no done pulse, `ptr` ← `idx+1` mod `N_REQ`, `count` ← 0.
  - Otherwise, if `count == final_reg`, next state is `ACK` and `count` holds.
  - Otherwise `count` ← `count+1`.
  - Abort takes priority over completion when both occur in the same cycle.
- **ACK**
  - `done[idx]` = 1, `gnt[idx]` = 1, `count` holds `final_reg`.
  - Next state is `IDLE`, `ptr` ← `idx+1` mod `N_REQ`, `count` ← 0.
- Changes to `delay` after the grant edge are ignored; the delay is latched in `final_reg`.
- Arithmetic is unsigned. `count` never exceeds `final_reg`, so no wrap occurs. `delay` = 2^W−1 is legal.
- `req` still high during `ACK` is treated as a new request at `IDLE`. The requester must drop `req` on seeing `done` if it wants no repeat.
- Requests from non-granted requesters are held pending with no effect on the current run.
- Fairness: after any grant completes or aborts, the granted requester gets lowest priority. Under continuous contention, a requester waits at most `N_REQ-1` runs.
- `gnt`, `done`, `busy` and `count` are decoded from registered state only. None of them has a combinational path from `req`.

## Timing
- While `reset` is asserted (asynchronously): `state` = `IDLE`, `ptr` = 0, `idx` = 0, `final_reg` = 0, `count` = 0. Outputs: `gnt` = 0, `done` = 0, `busy` = 0.
- Asserting `reset` mid-`RUN` or mid-`ACK` drops `gnt`/`done`/`busy` immediately. After release, the first arbitration occurs at the first rising edge with `req` nonzero.
- With `req` sampled at edge E in `IDLE`:
  - `gnt` and `busy` rise after E, and `count` = 0 in cycle E..E+1.
  - `count` = `k` in the cycle after edge E+k, for `k` ≤ `D`.
  - `done` is high in the cycle after edge E+D+1, for exactly one cycle.
  - `gnt` and `busy` fall after edge E+D+2.
- Grant-to-done latency is `D+1` cycles. Total occupancy is `D+2` cycles. `D` = 0 gives `done` one cycle after grant.
- Back-to-back requests: the next grant edge is the edge after `ACK`, so `busy` has one low cycle between runs.
- Abort: `gnt` and `busy` fall one cycle after the edge that samples `req[idx]` = 0.

## Test plan
- **Reset values:** assert `reset` with `req` = 4'b1111 → `gnt` = 0, `done` = 0, `busy` = 0, `count` = 0. Release, then the first grant goes to index 0 (`ptr` = 0).
- **Single request:** `req[2]` high, `delay[2]` = 5 → `gnt` = 4'b0100. `count` steps 0..5. `done` = 4'b0100 exactly 6 cycles after the grant edge, then `busy` = 0 for ≥1 cycle.
- **Zero delay and maximum delay:** `delay` = 0 → `done` 1 cycle after grant. `delay` = 255 (W = 8) → `done` 256 cycles after grant, with `count` never wrapping.
- **Round-robin:** all `req` held high, all delays = 2, each requester drops `req` on its `done` → grants in order 0, 1, 2, 3. Re-raise `req[0]` and `req[3]` with `ptr` = 0 → index 0 is granted before 3.
- **Abort:** `req[1]` granted with `delay` = 10, `req[1]` dropped at `count` = 4 → no `done`. `gnt` clears next cycle. A pending `req[0]` is granted after `ptr` advances to 2 and wraps.
- **Mid-run changes and reset:** change `delay[idx]` from 5 to 1 during `RUN` → completion still at `count` = 5. Separately, assert `reset` at `count` = 3 → outputs clear immediately, and the run does not resume after release.
